ttt_move_sequencer: RTL and testbench

Upstream move sequencer for `tic_tac_toe_game`. Accepts player move requests over a valid/ready handshake and validates them against the live board. It drives the game's `play`/`player_position` strobe, then selects the computer's reply from the board and drives `pc`/`computer_position`. It waits for the board to reflect each move and locks up once `who` reports an outcome.

---
 rtl/ttt_move_sequencer.sv | 244 ++++++++++++++++++++++++
 tb/tb_ttt_move_sequencer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ttt_move_sequencer.sv
// ttt_move_sequencer: validates player move requests against the live board,
// strobes them into tic_tac_toe_game, then picks and strobes the computer reply.
// Optional feature: define TTT_MOVE_STRATEGY_EN for win/block/centre/corner/edge
// reply selection; without it the reply is the lowest-index empty cell.
module ttt_move_sequencer #(
    parameter int unsigned PULSE_CYCLES = 2,
    parameter int unsigned WAIT_TIMEOUT = 15
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       req_valid,
    input  logic [3:0] req_pos,
    output logic       req_ready,
    input  logic [1:0] pos1,
    input  logic [1:0] pos2,
    input  logic [1:0] pos3,
    input  logic [1:0] pos4,
    input  logic [1:0] pos5,
    input  logic [1:0] pos6,
    input  logic [1:0] pos7,
    input  logic [1:0] pos8,
    input  logic [1:0] pos9,
    input  logic [1:0] who,
    output logic       play,
    output logic [3:0] player_position,
    output logic       pc,
    output logic [3:0] computer_position,
    output logic       err_illegal,
    output logic       err_timeout,
    output logic       game_over
);

    localparam int unsigned PW = 4;
    localparam int unsigned TW = 8;
    localparam logic [1:0] EMPTY  = 2'b00;
    localparam logic [1:0] PLAYER = 2'b01;
    localparam logic [1:0] COMP   = 2'b10;

    typedef enum logic [2:0] {
        IDLE, P_ISSUE, P_WAIT, C_PICK, C_ISSUE, C_WAIT, OVER
    } state_t;

    state_t           state;
    logic [PW-1:0]    pulse_cnt;
    logic [TW-1:0]    wait_cnt;
    logic [TW-1:0]    wait_next;
    logic [8:0][1:0]  board;
    logic [1:0]       req_cell;
    logic [1:0]       p_cell;
    logic [1:0]       c_cell;
    logic             req_legal;
    logic             any_empty;
    logic             timed_out;
    logic [3:0]       pick_pos;
    logic             pick_found;

    assign board = {pos9, pos8, pos7, pos6, pos5, pos4, pos3, pos2, pos1};

    // Cells beyond 8 read as occupied so they can never be accepted
    function automatic logic [1:0] cell_at(input logic [8:0][1:0] b, input logic [3:0] idx);
        if (idx > 4'd8) return 2'b11;
        return b[idx];
    endfunction

`ifdef TTT_MOVE_STRATEGY_EN
    function automatic logic pair_is(input logic [1:0] x, input logic [1:0] y, input logic [1:0] v);
        return (x == v) && (y == v);
    endfunction

    // True when cell i would complete a line whose other two cells hold v
    function automatic logic completes(input logic [8:0][1:0] b, input logic [3:0] i, input logic [1:0] v);
        logic r;
        r = 1'b0;
        case (i)
            4'd0: r = pair_is(b[1], b[2], v) | pair_is(b[3], b[6], v) | pair_is(b[4], b[8], v);
            4'd1: r = pair_is(b[0], b[2], v) | pair_is(b[4], b[7], v);
            4'd2: r = pair_is(b[0], b[1], v) | pair_is(b[5], b[8], v) | pair_is(b[4], b[6], v);
            4'd3: r = pair_is(b[4], b[5], v) | pair_is(b[0], b[6], v);
            4'd4: r = pair_is(b[3], b[5], v) | pair_is(b[1], b[7], v) | pair_is(b[0], b[8], v) | pair_is(b[2], b[6], v);
            4'd5: r = pair_is(b[3], b[4], v) | pair_is(b[2], b[8], v);
            4'd6: r = pair_is(b[7], b[8], v) | pair_is(b[0], b[3], v) | pair_is(b[2], b[4], v);
            4'd7: r = pair_is(b[6], b[8], v) | pair_is(b[1], b[4], v);
            4'd8: r = pair_is(b[6], b[7], v) | pair_is(b[2], b[5], v) | pair_is(b[0], b[4], v);
            default: r = 1'b0;
        endcase
        return r;
    endfunction
`endif

    // Board lookups, request legality and wait-timeout detection
    always_comb begin
        req_cell  = cell_at(board, req_pos);
        p_cell    = cell_at(board, player_position);
        c_cell    = cell_at(board, computer_position);
        req_legal = (req_pos <= 4'd8) && (req_cell == EMPTY);
        any_empty = 1'b0;
        for (int i = 0; i < 9; i++) begin
            if (board[i] == EMPTY) any_empty = 1'b1;
        end
        wait_next = TW'(wait_cnt + TW'(1));
        timed_out = (wait_next == TW'(WAIT_TIMEOUT));
    end

    // Computer reply selection from the current board
    always_comb begin
        pick_pos   = 4'd0;
        pick_found = 1'b0;
`ifdef TTT_MOVE_STRATEGY_EN
        for (int i = 0; i < 9; i++) begin
            if (!pick_found && board[i] == EMPTY && completes(board, 4'(i), COMP)) begin
                pick_pos   = 4'(i);
                pick_found = 1'b1;
            end
        end
        for (int i = 0; i < 9; i++) begin
            if (!pick_found && board[i] == EMPTY && completes(board, 4'(i), PLAYER)) begin
                pick_pos   = 4'(i);
                pick_found = 1'b1;
            end
        end
        if (!pick_found) begin
            if      (board[4] == EMPTY) pick_pos = 4'd4;
            else if (board[0] == EMPTY) pick_pos = 4'd0;
            else if (board[2] == EMPTY) pick_pos = 4'd2;
            else if (board[6] == EMPTY) pick_pos = 4'd6;
            else if (board[8] == EMPTY) pick_pos = 4'd8;
            else if (board[1] == EMPTY) pick_pos = 4'd1;
            else if (board[3] == EMPTY) pick_pos = 4'd3;
            else if (board[5] == EMPTY) pick_pos = 4'd5;
            else if (board[7] == EMPTY) pick_pos = 4'd7;
            else                        pick_pos = 4'd0;
        end
`else
        for (int i = 0; i < 9; i++) begin
            if (!pick_found && board[i] == EMPTY) begin
                pick_pos   = 4'(i);
                pick_found = 1'b1;
            end
        end
`endif
    end

    // Move sequencing FSM with registered outputs
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state             <= IDLE;
            pulse_cnt         <= '0;
            wait_cnt          <= '0;
            req_ready         <= 1'b0;
            play              <= 1'b0;
            pc                <= 1'b0;
            player_position   <= 4'd0;
            computer_position <= 4'd0;
            err_illegal       <= 1'b0;
            err_timeout       <= 1'b0;
            game_over         <= 1'b0;
        end else begin
            err_illegal <= 1'b0;
            case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (who != 2'b00) begin
                        state     <= OVER;
                        req_ready <= 1'b0;
                        game_over <= 1'b1;
                    end else if (req_valid && req_ready) begin
                        if (req_legal) begin
                            player_position <= req_pos;
                            play            <= 1'b1;
                            pulse_cnt       <= PW'(1);
                            req_ready       <= 1'b0;
                            state           <= P_ISSUE;
                        end else begin
                            err_illegal <= 1'b1;
                        end
                    end
                end
                P_ISSUE: begin
                    if (pulse_cnt == PW'(PULSE_CYCLES)) begin
                        play     <= 1'b0;
                        wait_cnt <= '0;
                        state    <= P_WAIT;
                    end else begin
                        pulse_cnt <= PW'(pulse_cnt + PW'(1));
                    end
                end
                P_WAIT: begin
                    if (p_cell == PLAYER) begin
                        if (who != 2'b00 || !any_empty) begin
                            state     <= OVER;
                            game_over <= 1'b1;
                        end else begin
                            state <= C_PICK;
                        end
                    end else if (timed_out) begin
                        err_timeout <= 1'b1;
                        req_ready   <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        wait_cnt <= wait_next;
                    end
                end
                C_PICK: begin
                    computer_position <= pick_pos;
                    pc                <= 1'b1;
                    pulse_cnt         <= PW'(1);
                    state             <= C_ISSUE;
                end
                C_ISSUE: begin
                    if (pulse_cnt == PW'(PULSE_CYCLES)) begin
                        pc       <= 1'b0;
                        wait_cnt <= '0;
                        state    <= C_WAIT;
                    end else begin
                        pulse_cnt <= PW'(pulse_cnt + PW'(1));
                    end
                end
                C_WAIT: begin
                    if (c_cell == COMP) begin
                        if (who != 2'b00) begin
                            state     <= OVER;
                            game_over <= 1'b1;
                        end else begin
                            req_ready <= 1'b1;
                            state     <= IDLE;
                        end
                    end else if (timed_out) begin
                        err_timeout <= 1'b1;
                        req_ready   <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        wait_cnt <= wait_next;
                    end
                end
                OVER: begin
                    req_ready <= 1'b0;
                    game_over <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ttt_move_sequencer.sv
// Directed bench for ttt_move_sequencer with a small board model that writes
// the player/computer marks when it sees the play/pc strobes.
module tb_ttt_move_sequencer;

`ifdef TTT_MOVE_STRATEGY_EN
    localparam logic [3:0] EXP_FIRST_CP = 4'd4;
`else
    localparam logic [3:0] EXP_FIRST_CP = 4'd1;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic       req_valid;
    logic [3:0] req_pos;
    logic       req_ready;
    logic [1:0] board [9];
    logic [1:0] who;
    logic       play;
    logic [3:0] player_position;
    logic       pc;
    logic [3:0] computer_position;
    logic       err_illegal;
    logic       err_timeout;
    logic       game_over;
    logic       model_en;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    ttt_move_sequencer #(.PULSE_CYCLES(2), .WAIT_TIMEOUT(15)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_pos(req_pos), .req_ready(req_ready),
        .pos1(board[0]), .pos2(board[1]), .pos3(board[2]),
        .pos4(board[3]), .pos5(board[4]), .pos6(board[5]),
        .pos7(board[6]), .pos8(board[7]), .pos9(board[8]),
        .who(who), .play(play), .player_position(player_position),
        .pc(pc), .computer_position(computer_position),
        .err_illegal(err_illegal), .err_timeout(err_timeout), .game_over(game_over)
    );

    // Game model: marks the strobed cell on the board
    always @(negedge clock) begin
        if (model_en) begin
            if (play) board[player_position] = 2'b01;
            if (pc)   board[computer_position] = 2'b10;
        end
    end

    task automatic clear_board();
        for (int i = 0; i < 9; i++) board[i] = 2'b00;
    endtask

    task automatic do_reset();
        reset = 1'b0; req_valid = 1'b0; req_pos = 4'd0; who = 2'b00; model_en = 1'b0;
        clear_board();
        repeat (2) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
    endtask

    task automatic send_req(input logic [3:0] p);
        @(negedge clock);
        req_valid = 1'b1; req_pos = p;
        @(negedge clock);
        req_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0; req_valid = 1'b0; req_pos = 4'd0; who = 2'b00; model_en = 1'b0;
        clear_board();
        repeat (5) @(negedge clock);
        checks++;
        if ({req_ready, play, pc, err_illegal, err_timeout, game_over} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags got %b want 000000", {req_ready, play, pc, err_illegal, err_timeout, game_over});
        end
        checks++;
        if ({player_position, computer_position} !== 8'h00) begin
            errors++;
            $display("FAIL reset_positions got %h want 00", {player_position, computer_position});
        end
        reset = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b0) begin
            errors++; $display("FAIL ready_before_edge got %b want 0", req_ready);
        end
        @(negedge clock);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL ready_after_edge got %b want 1", req_ready);
        end
    endtask

    task automatic test_first_move();
        int n;
        int hi;
        model_en = 1'b1;
        send_req(4'd0);
        checks++;
        if (play !== 1'b1 || player_position !== 4'd0) begin
            errors++; $display("FAIL play_cycle1 got play=%b pos=%0d want 1/0", play, player_position);
        end
        @(negedge clock);
        checks++;
        if (play !== 1'b1) begin
            errors++; $display("FAIL play_cycle2 got %b want 1", play);
        end
        @(negedge clock);
        checks++;
        if (play !== 1'b0) begin
            errors++; $display("FAIL play_end got %b want 0", play);
        end
        n = 0;
        while (pc !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (n != 2) begin
            errors++; $display("FAIL pc_latency got %0d cycles want 2", n);
        end
        checks++;
        if (computer_position !== EXP_FIRST_CP) begin
            errors++; $display("FAIL first_cp got %0d want %0d", computer_position, EXP_FIRST_CP);
        end
        hi = 0;
        while (pc === 1'b1 && hi < 10) begin
            checks++;
            if (play !== 1'b0) begin
                errors++; $display("FAIL play_pc_overlap got play=%b want 0", play);
            end
            hi++;
            @(negedge clock);
        end
        checks++;
        if (hi != 2) begin
            errors++; $display("FAIL pc_width got %0d want 2", hi);
        end
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (req_ready !== 1'b1 || err_timeout !== 1'b0) begin
            errors++; $display("FAIL move_done got ready=%b tmo=%b want 1/0", req_ready, err_timeout);
        end
        model_en = 1'b0;
    endtask

    task automatic test_illegal();
        logic [3:0] bad [2];
        bad[0] = 4'd9;
        bad[1] = 4'd4;
        board[4] = 2'b10;
        for (int k = 0; k < 2; k++) begin
            send_req(bad[k]);
            checks++;
            if (err_illegal !== 1'b1 || play !== 1'b0) begin
                errors++; $display("FAIL illegal_pulse pos=%0d got err=%b play=%b want 1/0", bad[k], err_illegal, play);
            end
            @(negedge clock);
            checks++;
            if (err_illegal !== 1'b0 || req_ready !== 1'b1 || play !== 1'b0) begin
                errors++; $display("FAIL illegal_after pos=%0d got err=%b rdy=%b play=%b want 0/1/0", bad[k], err_illegal, req_ready, play);
            end
        end
    endtask

    task automatic test_win_block();
        int n;
        do_reset();
        board[0] = 2'b10;
        board[1] = 2'b10;
        model_en = 1'b1;
        send_req(4'd8);
        n = 0;
        while (pc !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (pc !== 1'b1 || computer_position !== 4'd2) begin
            errors++; $display("FAIL win_cp got pc=%b cp=%0d want 1/2", pc, computer_position);
        end
        who = 2'b10;
        n = 0;
        while (game_over !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (game_over !== 1'b1 || req_ready !== 1'b0 || pc !== 1'b0) begin
            errors++; $display("FAIL game_over got over=%b rdy=%b pc=%b want 1/0/0", game_over, req_ready, pc);
        end
        send_req(4'd5);
        checks++;
        if (play !== 1'b0 || err_illegal !== 1'b0 || game_over !== 1'b1) begin
            errors++; $display("FAIL over_locked got play=%b err=%b over=%b want 0/0/1", play, err_illegal, game_over);
        end
        model_en = 1'b0;
    endtask

    task automatic test_timeout();
        do_reset();
        send_req(4'd3);
        for (int k = 1; k <= 17; k++) begin
            @(negedge clock);
            if (k == 16) begin
                checks++;
                if (err_timeout !== 1'b0) begin
                    errors++; $display("FAIL timeout_early got %b want 0", err_timeout);
                end
            end
            if (k == 17) begin
                checks++;
                if (err_timeout !== 1'b1 || req_ready !== 1'b1 || play !== 1'b0) begin
                    errors++; $display("FAIL timeout_hit got tmo=%b rdy=%b play=%b want 1/1/0", err_timeout, req_ready, play);
                end
            end
        end
        repeat (3) @(negedge clock);
        checks++;
        if (err_timeout !== 1'b1) begin
            errors++; $display("FAIL timeout_sticky got %b want 1", err_timeout);
        end
    endtask

    task automatic test_reset_mid_pc();
        int n;
        clear_board();
        who = 2'b00;
        model_en = 1'b1;
        send_req(4'd0);
        n = 0;
        while (pc !== 1'b1 && n < 20) begin
            @(negedge clock);
            n++;
        end
        checks++;
        if (pc !== 1'b1) begin
            errors++; $display("FAIL midpc_reach got pc=%b want 1", pc);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (pc !== 1'b0 || play !== 1'b0 || err_timeout !== 1'b0) begin
            errors++; $display("FAIL midpc_async got pc=%b play=%b tmo=%b want 0/0/0", pc, play, err_timeout);
        end
        @(negedge clock);
        model_en = 1'b0;
        clear_board();
        reset = 1'b1;
        @(negedge clock);
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL midpc_ready got %b want 1", req_ready);
        end
        send_req(4'd5);
        checks++;
        if (play !== 1'b1 || player_position !== 4'd5) begin
            errors++; $display("FAIL midpc_new got play=%b pos=%0d want 1/5", play, player_position);
        end
    endtask

    initial begin
        test_reset();
        test_first_move();
        test_illegal();
        test_win_block();
        test_timeout();
        test_reset_mid_pc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

endmodule
